// File: rtl/defines.vh
// Shared field widths for the memory request path.
`ifndef ADDRESS_WIDTH
`define ADDRESS_WIDTH 32
`endif
`ifndef ID_WIDTH
`define ID_WIDTH 8
`endif

// File: rtl/request_buffer.sv
// First-word-fall-through request buffer between the address-offset stage and memory.
// Optional macro REQUEST_BUFFER_ISSUE_COUNT_EN adds a 16-bit issued-request counter.
`include "defines.vh"

module request_buffer #(
  parameter int unsigned DEPTH = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [`ADDRESS_WIDTH-1:0] in_address,
  input  logic [`ID_WIDTH-1:0]      in_id,
  input  logic                      in_valid,
  output logic                      out_stall,
  input  logic                      flush,
  output logic [`ADDRESS_WIDTH-1:0] mem_address,
  output logic [`ID_WIDTH-1:0]      mem_id,
  output logic                      mem_valid,
  input  logic                      mem_ready,
  output logic [$clog2(DEPTH):0]    count
`ifdef REQUEST_BUFFER_ISSUE_COUNT_EN
  ,
  output logic [15:0]               issue_count
`endif
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t                    r_state;
  logic [PW-1:0]             r_wptr;
  logic [PW-1:0]             r_rptr;
  logic [CW-1:0]             r_count;
  logic [`ADDRESS_WIDTH-1:0] r_addr [DEPTH];
  logic [`ID_WIDTH-1:0]      r_id   [DEPTH];

  logic          w_push;
  logic          w_pop;
  logic          w_nonempty;
  logic [CW-1:0] w_count_after_pop;
  logic [CW-1:0] w_count_next;

  always_comb begin
    w_nonempty        = (r_count != '0);
    out_stall         = (r_count == CW'(DEPTH)) || flush || (r_state == FLUSH);
    mem_valid         = w_nonempty && (r_state != FLUSH);
    w_push            = in_valid && !out_stall;
    w_pop             = mem_valid && mem_ready;
    w_count_after_pop = r_count - CW'(w_pop);
    w_count_next      = w_count_after_pop + CW'(w_push);
    // Storage is not reset; an empty buffer presents zeros instead of stale data.
    mem_address       = w_nonempty ? r_addr[r_rptr] : '0;
    mem_id            = w_nonempty ? r_id[r_rptr]   : '0;
    count             = r_count;
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_addr[r_wptr] <= in_address;
      r_id[r_wptr]   <= in_id;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      case (r_state)
        IDLE, BUSY: begin
          r_wptr  <= r_wptr + PW'(w_push);
          r_rptr  <= r_rptr + PW'(w_pop);
          r_count <= w_count_next;
          // A flush stalls upstream, so no push can coincide with it.
          if (flush && (w_count_after_pop != '0))
            r_state <= FLUSH;
          else if (w_count_next == '0)
            r_state <= IDLE;
          else
            r_state <= BUSY;
        end
        FLUSH: begin
          if (w_nonempty) begin
            r_rptr  <= r_rptr + PW'(1);
            r_count <= r_count - CW'(1);
          end
          if (r_count <= CW'(1))
            r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef REQUEST_BUFFER_ISSUE_COUNT_EN
  logic [15:0] r_issue_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_issue_count <= '0;
    else if (w_pop)
      r_issue_count <= r_issue_count + 16'd1;
  end

  assign issue_count = r_issue_count;
`endif

endmodule
